// File: rtl/kgp_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kgp_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
//               fetch_entry_t is the record buffered between fetch and decode.
//               With FETCH_ALIGN_CHECK_EN defined, the entry carries a
//               misalign flag.
// Revision    : 1.0 - initial release
// ============================================================================
package kgp_fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    // Instruction substituted for reads that were never issued to memory
    localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
`ifdef FETCH_ALIGN_CHECK_EN
        logic               misalign;
`endif
    } fetch_entry_t;

endpackage : kgp_fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small circular FIFO for fetched instructions. Push and pop
//               may occur together at any occupancy. A synchronous flush
//               empties the FIFO and overrides push and pop in that cycle.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   i_push   : write i_data at the tail
//   i_data   : entry to write
//   i_pop    : remove the head entry (ignored when empty)
//   i_flush  : discard all entries
//   o_count  : number of stored entries
//   o_head   : head entry (meaningful only when o_count != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int  DEPTH   = 3,
    parameter type entry_t = logic [7:0],
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  entry_t           i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output entry_t           o_head
);

    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    // A full FIFO can still accept a push when the head leaves in the same cycle
    assign w_push_ok = i_push && ((r_count != c_full_cnt) || w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible through r_count
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Accepts PCs over a valid/ready
//               handshake, issues word reads to a 1-cycle-latency
//               synchronous instruction memory, and queues (pc, instr) pairs
//               for decode. A redirect flushes queued and in-flight fetches.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned PCs
//               are not read and are flagged on instr_misalign).
//   clk, rst        : clock, asynchronous active-high reset
//   pc_in/valid     : fetch address handshake input; pc_ready output
//   redirect        : branch taken, flush everything this cycle
//   imem_en/addr    : memory read strobe and word-aligned address
//   imem_rdata      : memory data, valid the cycle after imem_en
//   instr/instr_pc  : head instruction and its PC
//   instr_valid     : head entry valid; instr_ready consumes it
//   instr_misalign  : head came from a misaligned PC (macro builds only)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    input  logic               redirect,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic               instr_misalign,
`endif
    input  logic               instr_ready
);

    import kgp_fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [CNT_W-1:0] w_count;
    logic [OCC_W-1:0] w_occupancy;
    logic             w_issue;
    logic             w_kill;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    fetch_entry_t     w_entry;
    fetch_entry_t     w_head;

    logic              r_inflight;
    logic [ADDR_W-1:0] r_req_pc;

    // An outstanding read reserves a FIFO slot so its data always has room
    assign w_occupancy = {1'b0, w_count} + OCC_W'(r_inflight);
    assign pc_ready    = !rst && !redirect && (w_occupancy < OCC_W'(DEPTH));
    assign w_issue     = pc_valid && pc_ready;
    assign imem_addr   = {pc_in[ADDR_W-1:2], 2'b00};

    // The only response that can be wrong-path is the one returning in the
    // redirect cycle itself, so kill lives for exactly that cycle.
    assign w_kill = redirect && r_inflight;
    assign w_push = r_inflight && !w_kill;

`ifdef FETCH_ALIGN_CHECK_EN
    logic w_aligned;
    logic r_req_misalign;

    assign w_aligned = (pc_in[1:0] == 2'b00);
    assign imem_en   = w_issue && w_aligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_misalign <= 1'b0;
        end else if (w_issue) begin
            r_req_misalign <= !w_aligned;
        end
    end

    assign w_entry.pc       = r_req_pc;
    assign w_entry.instr    = r_req_misalign ? INSTR_NOP : imem_rdata;
    assign w_entry.misalign = r_req_misalign;
`else
    assign imem_en       = w_issue;
    assign w_entry.pc    = r_req_pc;
    assign w_entry.instr = imem_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_req_pc   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_req_pc <= pc_in;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign w_nonempty  = (w_count != '0);
    assign instr_valid = w_nonempty && !redirect;
    assign w_pop       = instr_valid && instr_ready;

    // Outputs read as zero whenever the FIFO is empty, including in reset
    assign instr    = w_nonempty ? w_head.instr : INSTR_NOP;
    assign instr_pc = w_nonempty ? w_head.pc : '0;
`ifdef FETCH_ALIGN_CHECK_EN
    assign instr_misalign = w_nonempty && w_head.misalign;
`endif

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch (DEPTH=3). Directed
//               stimulus pushes expected (pc, instr) pairs into a queue; a
//               monitor pops and compares on every decode handshake.
//               Honours FETCH_ALIGN_CHECK_EN for the misalign port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        redirect;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        instr_misalign;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } exp_t;

    exp_t sb_q[$];

    instr_fetch #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .DEPTH   (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .redirect       (redirect),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
`ifdef FETCH_ALIGN_CHECK_EN
        .instr_misalign (instr_misalign),
`endif
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory: word at byte address A holds ((A>>2)+1)*0x11
    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= ((imem_addr >> 2) + 32'd1) * 32'h11;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] ins, input logic mis);
        exp_t e;
        e.pc = pc;
        e.instr = ins;
        e.misalign = mis;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic redir);
        pc_valid    = v;
        pc_in       = pc;
        instr_ready = rdy;
        redirect    = redir;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: every decode handshake must match the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc=%0h instr=%0h required no output", instr_pc, instr);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", 64'(instr_pc), 64'(e.pc));
                check("sb_instr", 64'(instr), 64'(e.instr));
`ifdef FETCH_ALIGN_CHECK_EN
                check("sb_misalign", 64'(instr_misalign), 64'(e.misalign));
`endif
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // ---------------- reset ----------------
        rst = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("rst_pc_ready", 64'(pc_ready), 64'd0);
        check("rst_imem_en", 64'(imem_en), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", 64'(instr_pc), 64'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("post_rst_pc_ready", 64'(pc_ready), 64'd1);
        step();

        // ---------------- streaming ----------------
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("st_c0_ready", 64'(pc_ready), 64'd1);
        check("st_c0_en", 64'(imem_en), 64'd1);
        check("st_c0_addr", 64'(imem_addr), 64'h0);
        expect_out(32'h0, 32'h11, 1'b0);
        step();
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        at_neg();
        check("st_c1_valid", 64'(instr_valid), 64'd0);
        check("st_c1_ready", 64'(pc_ready), 64'd1);
        expect_out(32'h4, 32'h22, 1'b0);
        step();
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        at_neg();
        check("st_c2_ready", 64'(pc_ready), 64'd1);
        check("st_c2_valid", 64'(instr_valid), 64'd1);
        check("st_c2_pc", 64'(instr_pc), 64'h0);
        check("st_c2_instr", 64'(instr), 64'h11);
        expect_out(32'h8, 32'h33, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("st_c3_pc", 64'(instr_pc), 64'h4);
        check("st_c3_instr", 64'(instr), 64'h22);
        step();
        at_neg();
        check("st_c4_pc", 64'(instr_pc), 64'h8);
        check("st_c4_instr", 64'(instr), 64'h33);
        step();
        at_neg();
        check("st_c5_empty", 64'(instr_valid), 64'd0);
        step();

        // ---------------- backpressure ----------------
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        at_neg();
        check("bp_d0_ready", 64'(pc_ready), 64'd1);
        expect_out(32'h0, 32'h11, 1'b0);
        step();
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        at_neg();
        check("bp_d1_ready", 64'(pc_ready), 64'd1);
        expect_out(32'h4, 32'h22, 1'b0);
        step();
        drive(1'b1, 32'h8, 1'b0, 1'b0);
        at_neg();
        check("bp_d2_ready", 64'(pc_ready), 64'd1);
        expect_out(32'h8, 32'h33, 1'b0);
        step();
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("bp_full_ready", 64'(pc_ready), 64'd0);
            step();
        end
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        at_neg();
        check("bp_pop_cycle_ready", 64'(pc_ready), 64'd0);
        check("bp_head0", 64'(instr_pc), 64'h0);
        step();
        at_neg();
        check("bp_after_pop_ready", 64'(pc_ready), 64'd1);
        check("bp_head1", 64'(instr_pc), 64'h4);
        expect_out(32'hC, 32'h44, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("bp_head2", 64'(instr_pc), 64'h8);
        step();
        at_neg();
        check("bp_head3", 64'(instr_pc), 64'hC);
        step();
        at_neg();
        check("bp_drained", 64'(instr_valid), 64'd0);
        step();

        // ---------------- redirect with in-flight read ----------------
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        at_neg();
        check("rd_issue_en", 64'(imem_en), 64'd1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        at_neg();
        check("rd_redir_ready", 64'(pc_ready), 64'd0);
        check("rd_redir_en", 64'(imem_en), 64'd0);
        check("rd_redir_valid", 64'(instr_valid), 64'd0);
        step();
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        at_neg();
        check("rd_after_ready", 64'(pc_ready), 64'd1);
        check("rd_after_valid", 64'(instr_valid), 64'd0);
        expect_out(32'h40, 32'h121, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("rd_no_stale", 64'(instr_valid), 64'd0);
        step();
        at_neg();
        check("rd_new_valid", 64'(instr_valid), 64'd1);
        check("rd_new_pc", 64'(instr_pc), 64'h40);
        step();

        // ---------------- redirect and pop coincide ----------------
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h24, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        at_neg();
        check("rp_two_valid", 64'(instr_valid), 64'd1);
        check("rp_two_head", 64'(instr_pc), 64'h20);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        at_neg();
        check("rp_redir_valid", 64'(instr_valid), 64'd0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("rp_flushed_valid", 64'(instr_valid), 64'd0);
        check("rp_flushed_ready", 64'(pc_ready), 64'd1);
        step();

        // ---------------- misaligned PC ----------------
        drive(1'b1, 32'h6, 1'b1, 1'b0);
        at_neg();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_no_en", 64'(imem_en), 64'd0);
        expect_out(32'h6, 32'h0, 1'b1);
`else
        check("mis_en", 64'(imem_en), 64'd1);
        check("mis_addr_aligned", 64'(imem_addr), 64'h4);
        expect_out(32'h6, 32'h22, 1'b0);
`endif
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        at_neg();
        check("mis_valid", 64'(instr_valid), 64'd1);
        check("mis_pc", 64'(instr_pc), 64'h6);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_flag", 64'(instr_misalign), 64'd1);
        check("mis_instr", 64'(instr), 64'h0);
`endif
        step();

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h34, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h38, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h3C, 1'b0, 1'b0);
        #1;
        check("mr_pre_valid", 64'(instr_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mr_pc_ready", 64'(pc_ready), 64'd0);
        check("mr_imem_en", 64'(imem_en), 64'd0);
        check("mr_valid", 64'(instr_valid), 64'd0);
        check("mr_instr", 64'(instr), 64'd0);
        check("mr_instr_pc", 64'(instr_pc), 64'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        at_neg();
        check("mr_release_ready", 64'(pc_ready), 64'd1);
        check("mr_release_valid", 64'(instr_valid), 64'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            at_neg();
            check("mr_inflight_dropped", 64'(instr_valid), 64'd0);
            step();
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
